sram_timed: RTL and testbench

// Parametrised, clocked successor to the 8-bit async SRAM models. It is a work/backup
// RAM model with LANES byte lanes (UDS/LDS style), read access time counted in CLK

---
 rtl/sram_timed.sv | 229 ++++++++++++++++++++++
 tb/tb_sram_timed.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_timed.sv
// Clocked byte-lane SRAM model with counted read access time, minimum write-pulse
// enforcement, optional zero-fill sweep after reset and bus-protocol error counters.
module sram_timed #(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 16,
    parameter int LANES     = 2,
    parameter int READ_LAT  = 3,
    parameter int WRITE_MIN = 2,
    parameter int INIT_ZERO = 1
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DIN,
    output logic [DATA_W-1:0] DOUT,
    output logic [LANES-1:0]  DOUT_EN,
    input  logic              nCE,
    input  logic              nOE,
    input  logic              nWE,
    input  logic [LANES-1:0]  nBE,
    output logic              READY,
    output logic              VALID,
    output logic              ERR_OEWE,
    output logic [7:0]        ERR_COUNT
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int RCNT_W = $clog2(READ_LAT + 1);
    localparam int WCNT_W = $clog2(WRITE_MIN + 1);
    localparam logic [RCNT_W-1:0] RCNT_MAX = RCNT_W'(READ_LAT);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(WRITE_MIN);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_READ, S_WRITE} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
    logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic [LANES-1:0]    rbe_q, rbe_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [LANES-1:0]    wbe_q, wbe_d;
    logic                conflict_q, conflict_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [LANES-1:0]    dout_en_q, dout_en_d;
    logic                valid_q, valid_d;
    logic                err_oewe_q, err_oewe_d;
    logic [7:0]          err_count_q, err_count_d;

    logic                rd, wr, conflict, bus_active;
    logic                start_read, short_wr;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [LANES-1:0]    mem_wbe;
    logic [DATA_W-1:0]   rd_word;
    logic [8:0]          err_sum;

    assign rd         = !nCE && !nOE && nWE;
    assign wr         = !nCE && !nWE;
    assign conflict   = !nCE && !nOE && !nWE;
    assign bus_active = (state_q != S_INIT);

    // NOTE: every signal gets a default at the top of the block so no path leaves
    // it unassigned; that is what keeps this combinational block free of latches.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        rcnt_d      = rcnt_q;
        wcnt_d      = wcnt_q;
        raddr_d     = raddr_q;
        rbe_d       = rbe_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        wbe_d       = wbe_q;
        conflict_d  = 1'b0;
        err_oewe_d  = err_oewe_q;
        err_count_d = err_count_q;
        dout_d      = '0;
        dout_en_d   = '0;
        valid_d     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = waddr_q;
        mem_wdata   = wdata_q;
        mem_wbe     = ~wbe_q;
        start_read  = 1'b0;
        short_wr    = 1'b0;
        rd_word     = '0;
        err_sum     = '0;

        case (state_q)
            S_INIT: begin
                mem_we     = 1'b1;
                mem_addr   = init_cnt_q;
                mem_wdata  = '0;
                mem_wbe    = '1;
                init_cnt_d = init_cnt_q + ADDR_W'(1);
                if (&init_cnt_q) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (wr) begin
                    state_d = S_WRITE;
                    wcnt_d  = WCNT_W'(1);
                end else if (rd) begin
                    start_read = 1'b1;
                end
            end
            S_READ: begin
                if (wr) begin
                    state_d = S_WRITE;
                    wcnt_d  = WCNT_W'(1);
                end else if (rd) begin
                    if (ADDR == raddr_q && nBE == rbe_q) begin
                        if (rcnt_q != RCNT_MAX) rcnt_d = rcnt_q + RCNT_W'(1);
                    end else begin
                        start_read = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                if (wr) begin
                    if (wcnt_q != WCNT_MAX) wcnt_d = wcnt_q + WCNT_W'(1);
                end else begin
                    // End of pulse: commit only if it lasted long enough.
                    if (wcnt_q >= WCNT_MAX) mem_we = 1'b1;
                    else                    short_wr = 1'b1;
                    if (rd) start_read = 1'b1;
                    else    state_d = S_IDLE;
                end
            end
        endcase

        if (bus_active && wr) begin
            waddr_d = ADDR;
            wdata_d = DIN;
            wbe_d   = nBE;
        end

        if (start_read) begin
            state_d = S_READ;
            rcnt_d  = RCNT_W'(1);
            raddr_d = ADDR;
            rbe_d   = nBE;
        end

        if (state_d == S_READ && rcnt_d == RCNT_MAX) begin
            // Forward a write landing on this same edge so reads see the new data.
            rd_word = mem[ADDR];
            for (int l = 0; l < LANES; l++) begin
                if (mem_we && mem_addr == ADDR && mem_wbe[l])
                    rd_word[l*8 +: 8] = mem_wdata[l*8 +: 8];
                if (!nBE[l]) dout_d[l*8 +: 8] = rd_word[l*8 +: 8];
            end
            dout_en_d = ~nBE;
            valid_d   = 1'b1;
        end

        if (bus_active) begin
            conflict_d = conflict;
            if (conflict) begin
                err_oewe_d = 1'b1;
                dout_en_d  = '0;
            end
            err_sum = {1'b0, err_count_q} + 9'(short_wr) + 9'(conflict && !conflict_q);
            err_count_d = err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

    // NOTE: non-blocking assignments for all state so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state_q     <= (INIT_ZERO != 0) ? S_INIT : S_IDLE;
            init_cnt_q  <= '0;
            rcnt_q      <= '0;
            wcnt_q      <= '0;
            raddr_q     <= '0;
            rbe_q       <= '1;
            waddr_q     <= '0;
            wdata_q     <= '0;
            wbe_q       <= '1;
            conflict_q  <= 1'b0;
            dout_q      <= '0;
            dout_en_q   <= '0;
            valid_q     <= 1'b0;
            err_oewe_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            rcnt_q      <= rcnt_d;
            wcnt_q      <= wcnt_d;
            raddr_q     <= raddr_d;
            rbe_q       <= rbe_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            wbe_q       <= wbe_d;
            conflict_q  <= conflict_d;
            dout_q      <= dout_d;
            dout_en_q   <= dout_en_d;
            valid_q     <= valid_d;
            err_oewe_q  <= err_oewe_d;
            err_count_q <= err_count_d;
        end
    end

    // NOTE: the array has no reset; clearing is done by the INIT sweep so the
    // storage maps onto a plain RAM macro.
    always_ff @(posedge CLK) begin
        if (nRESET && mem_we) begin
            for (int l = 0; l < LANES; l++) begin
                if (mem_wbe[l]) mem[mem_addr][l*8 +: 8] <= mem_wdata[l*8 +: 8];
            end
        end
    end

    assign DOUT      = dout_q;
    assign DOUT_EN   = dout_en_q;
    assign VALID     = valid_q;
    assign READY     = bus_active;
    assign ERR_OEWE  = err_oewe_q;
    assign ERR_COUNT = err_count_q;

endmodule

// File: tb/tb_sram_timed.sv
// Scoreboard bench for sram_timed: transaction-level memory model predicts every
// VALID cycle and its data; a negedge monitor pops and compares.
module tb_sram_timed;

    localparam int ADDR_W    = 13;
    localparam int DEPTH     = 2 ** ADDR_W;
    localparam int READ_LAT  = 3;
    localparam int WRITE_MIN = 2;

    logic              CLK = 1'b0;
    logic              nRESET;
    logic [ADDR_W-1:0] ADDR;
    logic [15:0]       DIN;
    logic [15:0]       DOUT;
    logic [1:0]        DOUT_EN;
    logic              nCE, nOE, nWE;
    logic [1:0]        nBE;
    logic              READY, VALID, ERR_OEWE;
    logic [7:0]        ERR_COUNT;

    sram_timed #(
        .ADDR_W(ADDR_W), .DATA_W(16), .LANES(2), .READ_LAT(READ_LAT),
        .WRITE_MIN(WRITE_MIN), .INIT_ZERO(1)
    ) dut (
        .CLK(CLK), .nRESET(nRESET), .ADDR(ADDR), .DIN(DIN), .DOUT(DOUT),
        .DOUT_EN(DOUT_EN), .nCE(nCE), .nOE(nOE), .nWE(nWE), .nBE(nBE),
        .READY(READY), .VALID(VALID), .ERR_OEWE(ERR_OEWE), .ERR_COUNT(ERR_COUNT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic [1:0]  en;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model_mem [DEPTH];
    int          exp_err  = 0;
    logic        exp_oewe = 1'b0;
    int          total    = 0;
    int          bad      = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] keep_lanes(logic [15:0] d, logic [1:0] be);
        logic [15:0] r;
        r = d;
        if (be[0]) r[7:0]  = 8'h00;
        if (be[1]) r[15:8] = 8'h00;
        return r;
    endfunction

    // Monitor: every VALID cycle must match the oldest prediction in time and data.
    always @(negedge CLK) begin
        exp_t e;
        if (nRESET === 1'b1) begin
            if (VALID === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("valid_cycle", 32'(cyc), 32'(e.cyc));
                    check("read_data", 32'(DOUT), 32'(e.data));
                    check("read_en", 32'(DOUT_EN), 32'(e.en));
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                check("missing_valid", 32'(cyc), 32'(e.cyc) | 32'h8000_0000);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(int n);
        nCE = 1'b1; nOE = 1'b1; nWE = 1'b1;
        repeat (n) step();
    endtask

    task automatic bump_err();
        if (exp_err < 255) exp_err++;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'h0000;
        exp_err  = 0;
        exp_oewe = 1'b0;
    endtask

    // Reads hold ADDR/nBE for `hold` sampled edges; data is valid from edge READ_LAT on.
    task automatic do_read(logic [ADDR_W-1:0] a, logic [1:0] be, int hold);
        exp_t e;
        ADDR = a; nBE = be; nCE = 1'b0; nOE = 1'b0; nWE = 1'b1;
        for (int k = READ_LAT; k <= hold; k++) begin
            e.cyc  = cyc + k;
            e.data = keep_lanes(model_mem[a], be);
            e.en   = ~be;
            sb.push_back(e);
        end
        repeat (hold) step();
    endtask

    task automatic do_write(logic [ADDR_W-1:0] a, logic [15:0] d, logic [1:0] be,
                            int len, bit conf);
        ADDR = a; DIN = d; nBE = be; nCE = 1'b0; nWE = 1'b0; nOE = conf ? 1'b0 : 1'b1;
        step();
        if (conf) check("conflict_dout_en", 32'(DOUT_EN), 32'h0);
        repeat (len - 1) step();
        if (conf) begin
            exp_oewe = 1'b1;
            bump_err();
        end
        if (len >= WRITE_MIN) begin
            if (!be[0]) model_mem[a][7:0]  = d[7:0];
            if (!be[1]) model_mem[a][15:8] = d[15:8];
        end else begin
            bump_err();
        end
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        while (READY !== 1'b1 && n < DEPTH + 16) begin
            n++;
            step();
        end
        check("ready_low_cycles", 32'(n), 32'(DEPTH));
    endtask

    task automatic check_errs(string tag);
        check({tag, "_err_count"}, 32'(ERR_COUNT), 32'(exp_err));
        check({tag, "_err_oewe"}, 32'(ERR_OEWE), 32'(exp_oewe));
    endtask

    initial begin
        int  prev_cls;
        int  op;
        int  len;
        logic [1:0] be;
        logic [ADDR_W-1:0] a;

        nRESET = 1'b0; ADDR = '0; DIN = '0; nBE = 2'b00;
        nCE = 1'b1; nOE = 1'b1; nWE = 1'b1;
        model_clear();
        repeat (3) step();
        check("rst_valid", 32'(VALID), 32'h0);
        check("rst_dout", 32'(DOUT), 32'h0);
        check("rst_dout_en", 32'(DOUT_EN), 32'h0);
        check("rst_ready", 32'(READY), 32'h0);
        check_errs("rst");
        nRESET = 1'b1;
        wait_init();

        // Zero-filled after the sweep.
        do_read(13'h1234, 2'b00, 4);
        idle(1);

        // Full-word write then read with latency check.
        do_write(13'h0010, 16'hBEEF, 2'b00, 2, 1'b0);
        idle(1);
        do_read(13'h0010, 2'b00, 3);
        idle(1);

        // Lane 0 only, then a lane-1-only read.
        do_write(13'h0010, 16'h55AA, 2'b10, 2, 1'b0);
        idle(1);
        do_read(13'h0010, 2'b00, 3);
        idle(1);
        do_read(13'h0010, 2'b01, 3);
        idle(1);

        // Short pulse is rejected and counted.
        do_write(13'h0020, 16'hCAFE, 2'b00, 2, 1'b0);
        idle(1);
        do_write(13'h0020, 16'h1111, 2'b00, 1, 1'b0);
        idle(1);
        check_errs("short");
        do_read(13'h0020, 2'b00, 3);
        idle(1);

        // Address change mid-read restarts the access time.
        do_write(13'h0011, 16'hA5A5, 2'b00, 2, 1'b0);
        idle(1);
        do_read(13'h0010, 2'b00, 2);
        do_read(13'h0011, 2'b00, 4);
        idle(1);

        // Read straight into a conflicting write that still commits.
        do_read(13'h0010, 2'b00, 3);
        do_write(13'h0030, 16'h7777, 2'b00, 4, 1'b1);
        idle(1);
        check_errs("conflict");
        do_read(13'h0030, 2'b00, 3);
        idle(1);

        // Read-after-write with no idle gap, then disabled-lane cases.
        do_write(13'h0040, 16'h1357, 2'b00, 2, 1'b0);
        do_read(13'h0040, 2'b00, 3);
        idle(1);
        do_read(13'h0010, 2'b11, 3);
        idle(1);
        do_write(13'h0010, 16'h0F0F, 2'b11, 2, 1'b0);
        idle(1);
        check_errs("be_off");
        do_read(13'h0010, 2'b00, 3);
        idle(1);

        // Randomized mix; same-class back-to-back ops get an idle so pulses stay separate.
        prev_cls = 0;
        for (int i = 0; i < 200; i++) begin
            op = $urandom_range(0, 3);
            case ($urandom_range(0, 4))
                0: a = 13'h0010;
                1: a = 13'h0011;
                2: a = 13'h0012;
                3: a = 13'h0013;
                default: a = 13'h1234;
            endcase
            be = 2'($urandom_range(0, 3));
            if (op == 0) begin
                if (prev_cls == 1) idle(1);
                do_read(a, be, $urandom_range(1, 5));
                prev_cls = 1;
            end else if (op <= 2) begin
                if (prev_cls == 2) idle(1);
                len = $urandom_range(1, 3);
                if (be == 2'b11 && len < WRITE_MIN) len = WRITE_MIN;
                do_write(a, 16'($urandom), be, len, op == 2);
                prev_cls = 2;
            end else begin
                idle($urandom_range(1, 2));
                prev_cls = 3;
            end
        end
        idle(READ_LAT + 2);
        check_errs("random");

        // Saturation of the violation counter.
        for (int i = 0; i < 260; i++) begin
            do_write(13'h0050, 16'($urandom), 2'b00, 1, 1'b0);
            idle(1);
        end
        check_errs("saturate");

        // Reset in the middle of a pulse: nothing commits, counters clear, sweep restarts.
        ADDR = 13'h0040; DIN = 16'hDEAD; nBE = 2'b00; nCE = 1'b0; nOE = 1'b1; nWE = 1'b0;
        step();
        nRESET = 1'b0;
        step();
        model_clear();
        check_errs("mid_rst");
        check("mid_rst_ready", 32'(READY), 32'h0);
        nRESET = 1'b1;
        nCE = 1'b1; nWE = 1'b1;
        wait_init();
        do_read(13'h0040, 2'b00, 3);
        idle(1);
        do_read(13'h0010, 2'b00, 3);
        idle(READ_LAT + 2);
        check_errs("final");
        check("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
